// File: rtl/synch_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds, non-power-of-two depth,
// overflow/underflow pulses and synchronous flush. Define FIFO_FWFT_EN for first-word fall-through reads.
module synch_fifo_prog #(
    parameter int FIFO_WIDTH    = 32,
    parameter int FIFO_DEEPTH   = 16,
    parameter int FIFO_PTR      = 4,
    parameter int AFULL_THRESH  = 14,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  fifo_clk,
    input  logic                  rst,
    input  logic                  fifo_flush,
    input  logic                  fifo_wren,
    input  logic [FIFO_WIDTH-1:0] fifo_wrdata,
    input  logic                  fifo_rden,
    output logic [FIFO_WIDTH-1:0] fifo_rddata,
    output logic                  fifo_rdvalid,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  fifo_almost_full,
    output logic                  fifo_almost_empty,
    output logic [FIFO_PTR:0]     fifo_data_avail,
    output logic [FIFO_PTR:0]     fifo_room_avail,
    output logic                  fifo_overflow,
    output logic                  fifo_underflow
);

    localparam int CNT_W = FIFO_PTR + 1;
    localparam logic [CNT_W-1:0]    DEPTH_C = CNT_W'(FIFO_DEEPTH);
    localparam logic [CNT_W-1:0]    AF_C    = CNT_W'(AFULL_THRESH);
    localparam logic [CNT_W-1:0]    AE_C    = CNT_W'(AEMPTY_THRESH);
    localparam logic [CNT_W-1:0]    ONE_C   = CNT_W'(1);
    localparam logic [FIFO_PTR-1:0] LAST_C  = FIFO_PTR'(FIFO_DEEPTH - 1);
    localparam logic [FIFO_PTR-1:0] PINC_C  = FIFO_PTR'(1);

    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEEPTH];

    logic [FIFO_PTR-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_PTR-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    room_q;
    logic                full_q, empty_q, afull_q, aempty_q;
    logic                ovf_q, udf_q;
    logic                wr_acc, rd_acc;

    // Acceptance looks only at registered flags; flush overrides both requests.
    always_comb begin
        wr_acc = fifo_wren & ~full_q  & ~fifo_flush;
        rd_acc = fifo_rden & ~empty_q & ~fifo_flush;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (fifo_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            // Explicit wrap so depths that are not a power of two work.
            if (wr_acc)
                wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + PINC_C;
            if (rd_acc)
                rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + PINC_C;
            case ({wr_acc, rd_acc})
                2'b10:   cnt_d = cnt_q + ONE_C;
                2'b01:   cnt_d = cnt_q - ONE_C;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Flags and counts are derived from next-state occupancy so they track the post-edge state.
    always_ff @(posedge fifo_clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            room_q   <= DEPTH_C;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            room_q   <= DEPTH_C - cnt_d;
            full_q   <= (cnt_d == DEPTH_C);
            empty_q  <= (cnt_d == '0);
            afull_q  <= (cnt_d >= AF_C);
            aempty_q <= (cnt_d <= AE_C);
            ovf_q    <= fifo_wren & full_q  & ~fifo_flush;
            udf_q    <= fifo_rden & empty_q & ~fifo_flush;
        end
    end

    // Storage is not reset; occupancy alone defines which entries are live.
    always_ff @(posedge fifo_clk) begin
        if (wr_acc)
            mem_q[wr_ptr_q] <= fifo_wrdata;
    end

`ifdef FIFO_FWFT_EN
    assign fifo_rddata  = mem_q[rd_ptr_q];
    assign fifo_rdvalid = ~empty_q;
`else
    logic [FIFO_WIDTH-1:0] rddata_q;
    logic                  rdvalid_q;

    always_ff @(posedge fifo_clk or negedge rst) begin
        if (!rst) begin
            rddata_q  <= '0;
            rdvalid_q <= 1'b0;
        end else begin
            rdvalid_q <= rd_acc;
            if (rd_acc)
                rddata_q <= mem_q[rd_ptr_q];
        end
    end

    assign fifo_rddata  = rddata_q;
    assign fifo_rdvalid = rdvalid_q;
`endif

    assign fifo_full         = full_q;
    assign fifo_empty        = empty_q;
    assign fifo_almost_full  = afull_q;
    assign fifo_almost_empty = aempty_q;
    assign fifo_data_avail   = cnt_q;
    assign fifo_room_avail   = room_q;
    assign fifo_overflow     = ovf_q;
    assign fifo_underflow    = udf_q;

endmodule

// File: tb/tb_synch_fifo_prog.sv
// Scoreboard bench for synch_fifo_prog: directed plan plus random traffic against a queue-based model.
module tb_synch_fifo_prog;
    localparam int W  = 32;
    localparam int D  = 16;
    localparam int P  = 4;
    localparam int AF = 14;
    localparam int AE = 2;

    logic          fifo_clk = 1'b0;
    logic          rst = 1'b0;
    logic          fifo_flush = 1'b0, fifo_wren = 1'b0, fifo_rden = 1'b0;
    logic [W-1:0]  fifo_wrdata = '0;
    logic [W-1:0]  fifo_rddata;
    logic          fifo_rdvalid, fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty;
    logic [P:0]    fifo_data_avail, fifo_room_avail;
    logic          fifo_overflow, fifo_underflow;

    synch_fifo_prog #(.FIFO_WIDTH(W), .FIFO_DEEPTH(D), .FIFO_PTR(P),
                      .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) dut (
        .fifo_clk(fifo_clk), .rst(rst), .fifo_flush(fifo_flush),
        .fifo_wren(fifo_wren), .fifo_wrdata(fifo_wrdata), .fifo_rden(fifo_rden),
        .fifo_rddata(fifo_rddata), .fifo_rdvalid(fifo_rdvalid),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_almost_full(fifo_almost_full), .fifo_almost_empty(fifo_almost_empty),
        .fifo_data_avail(fifo_data_avail), .fifo_room_avail(fifo_room_avail),
        .fifo_overflow(fifo_overflow), .fifo_underflow(fifo_underflow));

    always #5 fifo_clk = ~fifo_clk;

    typedef struct {
        int       avail;
        int       room;
        bit       full, empty, af, ae, ov, un, rv, rd_chk;
        logic [W-1:0] rdata;
    } status_t;

    logic [W-1:0] model[$];
    logic [W-1:0] rd_q[$];
    status_t      st_q[$];
    logic [W-1:0] last_rd = '0;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and record what the model says the DUT must show after the edge.
    task automatic cycle(input bit wr, input bit rd, input bit fl, input logic [W-1:0] d);
        status_t s;
        int n;
        bit full, empty;
        logic [W-1:0] v;
        @(negedge fifo_clk);
        fifo_wren = wr; fifo_rden = rd; fifo_flush = fl; fifo_wrdata = d;
        n = model.size();
        full = (n == D);
        empty = (n == 0);
        s.ov = 0; s.un = 0; s.rv = 0;
        if (fl) begin
            model.delete();
        end else begin
            s.ov = wr && full;
            s.un = rd && empty;
            if (rd && !empty) begin
                v = model.pop_front();
                last_rd = v;
                s.rv = 1;
`ifndef FIFO_FWFT_EN
                rd_q.push_back(v);
`endif
            end
            if (wr && !full) model.push_back(d);
        end
        n = model.size();
        s.avail = n; s.room = D - n;
        s.full = (n == D); s.empty = (n == 0);
        s.af = (n >= AF); s.ae = (n <= AE);
`ifdef FIFO_FWFT_EN
        s.rv = (n != 0);
        s.rd_chk = (n != 0);
        s.rdata = (n != 0) ? model[0] : '0;
`else
        s.rd_chk = 1;
        s.rdata = last_rd;
`endif
        st_q.push_back(s);
    endtask

    // Monitor: independent of stimulus, checks whatever the DUT presents after each edge.
    initial begin
        status_t s;
        forever begin
            @(posedge fifo_clk);
            #1;
`ifndef FIFO_FWFT_EN
            if (fifo_rdvalid === 1'b1) begin
                if (rd_q.size() == 0) chk("rdvalid_unexpected", 64'(fifo_rdvalid), 64'd0);
                else                  chk("rd_data", 64'(fifo_rddata), 64'(rd_q.pop_front()));
            end
`endif
            if (st_q.size() != 0) begin
                s = st_q.pop_front();
                chk("data_avail", 64'(fifo_data_avail), 64'(s.avail));
                chk("room_avail", 64'(fifo_room_avail), 64'(s.room));
                chk("full",       64'(fifo_full),        64'(s.full));
                chk("empty",      64'(fifo_empty),       64'(s.empty));
                chk("almost_full",  64'(fifo_almost_full),  64'(s.af));
                chk("almost_empty", 64'(fifo_almost_empty), 64'(s.ae));
                chk("overflow",   64'(fifo_overflow),    64'(s.ov));
                chk("underflow",  64'(fifo_underflow),   64'(s.un));
                chk("rdvalid",    64'(fifo_rdvalid),     64'(s.rv));
                if (s.rd_chk) chk("rddata_view", 64'(fifo_rddata), 64'(s.rdata));
            end
        end
    end

    task automatic check_reset_values();
        chk("rst_rdvalid", 64'(fifo_rdvalid), 64'd0);
`ifndef FIFO_FWFT_EN
        chk("rst_rddata", 64'(fifo_rddata), 64'd0);
`endif
        chk("rst_full", 64'(fifo_full), 64'd0);
        chk("rst_empty", 64'(fifo_empty), 64'd1);
        chk("rst_afull", 64'(fifo_almost_full), 64'd0);
        chk("rst_aempty", 64'(fifo_almost_empty), 64'd1);
        chk("rst_avail", 64'(fifo_data_avail), 64'd0);
        chk("rst_room", 64'(fifo_room_avail), 64'(D));
        chk("rst_ovf", 64'(fifo_overflow), 64'd0);
        chk("rst_udf", 64'(fifo_underflow), 64'd0);
    endtask

    task automatic random_phase(input int ncyc, input int pw, input int pr, input int pf);
        for (int i = 0; i < ncyc; i++)
            cycle($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
                  $urandom_range(0, 99) < pf, $urandom);
    endtask

    initial begin
        repeat (2) @(negedge fifo_clk);
        check_reset_values();
        @(negedge fifo_clk);
        rst = 1'b1;

        // Fill to full, then one rejected write.
        for (int i = 0; i < 16; i++) cycle(1, 0, 0, 32'h100 + 32'(i));
        cycle(1, 0, 0, 32'hDEAD);
        for (int i = 0; i < 16; i++) cycle(0, 1, 0, '0);
        cycle(0, 1, 0, '0);                       // underflow on empty
        cycle(1, 1, 0, 32'hA5);                   // write wins on empty
        cycle(0, 1, 0, '0);
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, 32'h200 + 32'(i));
        for (int i = 0; i < 40; i++) cycle(1, 1, 0, 32'h300 + 32'(i));
        for (int i = 0; i < 3; i++)  cycle(0, 1, 0, '0);
        cycle(1, 0, 1, 32'hBEEF);                 // flush beats write at count 7
        cycle(0, 0, 0, '0);
        // Full with both requests: read wins.
        for (int i = 0; i < 16; i++) cycle(1, 0, 0, 32'h400 + 32'(i));
        cycle(1, 1, 0, 32'hF00D);
        cycle(1, 1, 0, 32'hF00E);

        random_phase(250, 70, 30, 1);
        random_phase(250, 30, 70, 1);
        random_phase(250, 55, 55, 2);

        // Asynchronous reset mid-burst.
        for (int i = 0; i < 5; i++) cycle(1, i[0], 0, 32'h500 + 32'(i));
        @(posedge fifo_clk);
        #2;
        rst = 1'b0;
        fifo_wren = 1'b0; fifo_rden = 1'b0; fifo_flush = 1'b0;
        #1;
        check_reset_values();
        model.delete();
        rd_q.delete();
        last_rd = '0;
        @(negedge fifo_clk);
        @(negedge fifo_clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 32'h600 + 32'(i));
        random_phase(200, 50, 50, 1);
        for (int i = 0; i < 20; i++) cycle(0, 1, 0, '0);

        repeat (2) cycle(0, 0, 0, '0);
        @(posedge fifo_clk);
        #3;
        chk("scoreboard_drained", 64'(rd_q.size()), 64'd0);
        chk("status_drained", 64'(st_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/synch_fifo_prog.md
Name: synch_fifo_prog

Overview:
- Parametrised synchronous single-clock FIFO; next generation of the team's basic synchronous FIFO.
- Adds programmable almost-full and almost-empty thresholds, non-power-of-two depth, and overflow/underflow protection with error pulses.
- Adds a synchronous flush and a read-valid strobe.
- Sits between producer and consumer pipelines within one clock domain.
- Storage is an internal register array; no external RAM.

Parameters:
- FIFO_WIDTH, 32, data width in bits (>=1).
- FIFO_DEEPTH, 16, number of entries (>=2, any integer, not required to be a power of two).
- FIFO_PTR, 4, pointer width; must equal ceil(log2(FIFO_DEEPTH)). Count and avail widths are FIFO_PTR+1.
- AFULL_THRESH, 14, fifo_almost_full asserts when occupancy >= this value (1..FIFO_DEEPTH).
- AEMPTY_THRESH, 2, fifo_almost_empty asserts when occupancy <= this value (0..FIFO_DEEPTH-1).

Ports:
- fifo_clk, in, 1, clock; all logic on rising edge.
- rst, in, 1, asynchronous active-low reset.
- fifo_flush, in, 1, synchronous clear of contents.
- fifo_wren, in, 1, write request.
- fifo_wrdata, in, FIFO_WIDTH, write data.
- fifo_rden, in, 1, read request.
- fifo_rddata, out, FIFO_WIDTH, read data.
- fifo_rdvalid, out, 1, fifo_rddata holds newly read word.
- fifo_full, out, 1, occupancy == FIFO_DEEPTH.
- fifo_empty, out, 1, occupancy == 0.
- fifo_almost_full, out, 1, occupancy >= AFULL_THRESH.
- fifo_almost_empty, out, 1, occupancy <= AEMPTY_THRESH.
- fifo_data_avail, out, FIFO_PTR+1, occupancy.
- fifo_room_avail, out, FIFO_PTR+1, FIFO_DEEPTH - occupancy.
- fifo_overflow, out, 1, one-cycle pulse: write rejected.
- fifo_underflow, out, 1, one-cycle pulse: read rejected.

Behaviour:
- Reset: one clock, fifo_clk; reset rst is asynchronous, active-low.
  - Reset values: pointers 0, occupancy 0, fifo_rddata 0, fifo_rdvalid 0, fifo_full 0, fifo_empty 1, fifo_almost_full 0.
  - fifo_almost_empty 1; fifo_data_avail 0; fifo_room_avail FIFO_DEEPTH; fifo_overflow 0; fifo_underflow 0.
  - Reset asserted mid-operation discards all contents immediately. The first accepted write after release lands at entry 0.
- Acceptance:
  - A write is accepted when fifo_wren is high and fifo_full is low.
  - A read is accepted when fifo_rden is high and fifo_empty is low.
  - Decisions use registered flags from the current cycle.
- Simultaneous write and read:
  - When both are accepted, occupancy is unchanged and both pointers advance.
  - When full with wren and rden both high, the read is accepted and the write is rejected; occupancy becomes FIFO_DEEPTH-1.
  - When empty with wren and rden both high, the write is accepted and the read is rejected; occupancy becomes 1.
- Error pulses:
  - A rejected write raises fifo_overflow for exactly the next cycle. Memory, pointers and count are untouched.
  - A rejected read raises fifo_underflow for exactly the next cycle. fifo_rddata holds its value and fifo_rdvalid stays 0.
- Pointers: wr_ptr and rd_ptr wrap from FIFO_DEEPTH-1 to 0 (explicit compare, not natural binary rollover).
- Flags and counts:
  - All flags and counts are registered.
  - They are computed from next-state occupancy, so they reflect the post-update state in the cycle after the edge.
- Read path:
  - Latency is 1: on the edge accepting a read, fifo_rddata <= mem[rd_ptr] and fifo_rdvalid <= 1.
  - Otherwise fifo_rdvalid <= 0 and fifo_rddata holds.
- Flush:
  - fifo_flush high has priority over fifo_wren and fifo_rden in that cycle.
  - Next state: pointers 0, occupancy 0, all flags and counts at their reset values.
  - No overflow or underflow pulse is raised; fifo_rdvalid is 0; fifo_rddata holds.
- Width rule: occupancy arithmetic is FIFO_PTR+1 bits and never wraps, because acceptance gating prevents it.

Optional Feature:
- Macro name: FIFO_FWFT_EN.
- When defined (first-word fall-through):
  - fifo_rddata = mem[rd_ptr] combinationally.
  - fifo_rdvalid = ~fifo_empty.
  - fifo_rden acts as a pop acknowledge of the displayed word.
  - The first written word is visible one cycle after its write edge.
  - Underflow rules are unchanged.
- When undefined: the registered 1-cycle read path described under Behaviour applies.

Test Plan (FIFO_DEEPTH=16, AFULL_THRESH=14, AEMPTY_THRESH=2, FIFO_WIDTH=32):
- Release reset, write 0x100..0x10F over 16 cycles:
  - fifo_almost_empty drops after the 3rd write.
  - fifo_almost_full rises after the 14th write.
  - fifo_full=1, fifo_data_avail=16, fifo_room_avail=0.
- While full, wren=1 with wrdata 0xDEAD:
  - fifo_overflow pulses 1 cycle; count stays 16.
  - Subsequent 16 reads return 0x100..0x10F in order, each with fifo_rdvalid one cycle after rden.
  - Then fifo_empty=1.
- Empty FIFO, rden=1:
  - fifo_underflow pulses 1 cycle; fifo_rdvalid=0; fifo_rddata unchanged.
- Empty FIFO, wren=rden=1 with 0xA5:
  - Write accepted, read rejected, fifo_underflow=1, count=1.
  - Next read returns 0xA5.
- Fill to 10, then 40 cycles of simultaneous wren/rden with an incrementing pattern:
  - Count stays 10; pointers wrap past 15; data order preserved.
- Fill to 7, assert fifo_flush with wren=1:
  - Next cycle count=0, fifo_empty=1, no overflow.
  - Assert rst low mid-burst: outputs take reset values asynchronously.
  - Repeat the first scenario with FIFO_FWFT_EN defined: 0x100 appears on fifo_rddata one cycle after its write.
